// File: rtl/arb_pkg.sv
// Shared types and index helpers for the round-robin lock arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int calc_cw(input int n);
    return $clog2(n);
  endfunction

  // Advance a channel index by one, wrapping at n so non-power-of-two counts stay in range.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or after base, wrapping modulo N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = calc_cw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] base,
  output logic          any,
  output logic [CW-1:0] idx
);

  logic [CW:0] cand;

  // One extra bit on cand keeps base+k from overflowing before the modulo-N fold.
  always_comb begin
    any  = 1'b0;
    idx  = CW'(N - 1);
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, base} + (CW+1)'(k);
      if (cand >= (CW+1)'(N)) cand = cand - (CW+1)'(N);
      if (!any && req[cand[CW-1:0]]) begin
        any = 1'b1;
        idx = cand[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-channel round-robin arbiter with stall hold and optional burst locking; payload passes through combinationally.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int LOCK = 1,
  localparam int CW  = calc_cw(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   io_in_valid,
  output logic [N-1:0]   io_in_ready,
  input  logic [N*W-1:0] io_in_bits,
  input  logic [N-1:0]   io_in_last,
  output logic           io_out_valid,
  input  logic           io_out_ready,
  output logic [W-1:0]   io_out_bits,
  output logic [CW-1:0]  io_chosen
);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] lock_idx_q, lock_idx_d;
  logic          hold_q, hold_d;
  logic [CW-1:0] held_idx_q, held_idx_d;

  logic [CW-1:0] pick_base;
  logic          pick_any;
  logic [CW-1:0] pick_idx;
  logic          out_valid;
  logic [CW-1:0] chosen;
  logic          fire;

  always_comb begin
    pick_base = CW'(next_idx(int'(last_grant_q), N));
  end

  rr_pick #(.N(N), .CW(CW)) u_pick (
    .req  (io_in_valid),
    .base (pick_base),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // A lock outranks hold; a hold whose requester dropped falls back to a fresh pick this cycle.
  always_comb begin
    out_valid = pick_any;
    chosen    = pick_idx;
    if (state_q == LOCKED) begin
      out_valid = io_in_valid[lock_idx_q];
      chosen    = lock_idx_q;
    end else if (hold_q && io_in_valid[held_idx_q]) begin
      out_valid = 1'b1;
      chosen    = held_idx_q;
    end
  end

  always_comb begin
    fire         = out_valid & io_out_ready;
    io_out_valid = out_valid;
    io_chosen    = chosen;
    io_out_bits  = '0;
    io_in_ready  = '0;
    for (int i = 0; i < N; i++) begin
      if (out_valid && chosen == CW'(i)) io_out_bits = io_in_bits[i*W +: W];
      if (fire && chosen == CW'(i)) io_in_ready[i] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_idx_d   = lock_idx_q;
    hold_d       = out_valid & ~io_out_ready;
    held_idx_d   = hold_d ? chosen : held_idx_q;
    if (fire) begin
      last_grant_d = chosen;
      if (LOCK != 0) begin
        if (!io_in_last[chosen]) begin
          state_d    = LOCKED;
          lock_idx_d = chosen;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= CW'(N - 1);
      lock_idx_q   <= '0;
      hold_q       <= 1'b0;
      held_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_idx_q   <= lock_idx_d;
      hold_q       <= hold_d;
      held_idx_q   <= held_idx_d;
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed scoreboard bench for rr_lock_arbiter, with a LOCK=0 instance sharing the same inputs.
module tb_rr_lock_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock;
  logic           reset;
  logic [N-1:0]   io_in_valid;
  logic [N*W-1:0] io_in_bits;
  logic [N-1:0]   io_in_last;
  logic           io_out_ready;

  logic [N-1:0]   lk_in_ready;
  logic           lk_out_valid;
  logic [W-1:0]   lk_out_bits;
  logic [1:0]     lk_chosen;

  logic [N-1:0]   nl_in_ready;
  logic           nl_out_valid;
  logic [W-1:0]   nl_out_bits;
  logic [1:0]     nl_chosen;

  int n_compared;
  int n_mismatched;

  typedef struct {
    string      tag;
    logic       nl;
    logic       v;
    logic [1:0] c;
    logic [7:0] b;
    logic [3:0] r;
  } exp_t;

  exp_t sb[$];

  rr_lock_arbiter #(.N(N), .W(W), .LOCK(1)) u_dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (lk_in_ready),
    .io_in_bits   (io_in_bits),
    .io_in_last   (io_in_last),
    .io_out_valid (lk_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (lk_out_bits),
    .io_chosen    (lk_chosen)
  );

  rr_lock_arbiter #(.N(N), .W(W), .LOCK(0)) u_dut_nl (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (nl_in_ready),
    .io_in_bits   (io_in_bits),
    .io_in_last   (io_in_last),
    .io_out_valid (nl_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (nl_out_bits),
    .io_chosen    (nl_chosen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] valid, input logic ready, input logic [3:0] last);
    io_in_valid  = valid;
    io_out_ready = ready;
    io_in_last   = last;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [1:0] c,
                            input logic [7:0] b, input logic [3:0] r, input logic nl = 1'b0);
    exp_t e;
    e.tag = tag; e.nl = nl; e.v = v; e.c = c; e.b = b; e.r = r;
    sb.push_back(e);
  endtask

  // Compares every queued expectation at the falling edge, then steps to just after the next rising edge.
  task automatic check_output();
    exp_t e;
    @(negedge clock);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.nl) begin
        cmp({e.tag, ".valid"},  8'(nl_out_valid), 8'(e.v));
        cmp({e.tag, ".chosen"}, 8'(nl_chosen),    8'(e.c));
        cmp({e.tag, ".bits"},   nl_out_bits,      e.b);
        cmp({e.tag, ".ready"},  8'(nl_in_ready),  8'(e.r));
      end else begin
        cmp({e.tag, ".valid"},  8'(lk_out_valid), 8'(e.v));
        cmp({e.tag, ".chosen"}, 8'(lk_chosen),    8'(e.c));
        cmp({e.tag, ".bits"},   lk_out_bits,      e.b);
        cmp({e.tag, ".ready"},  8'(lk_in_ready),  8'(e.r));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply_stimulus(4'b0000, 1'b0, 4'b1111);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    io_in_bits   = {8'h13, 8'hA5, 8'h11, 8'h10};
    do_reset();

    // Reset state with nothing requesting.
    apply_stimulus(4'b0000, 1'b1, 4'b1111);
    expect_out("rst", 1'b0, 2'd3, 8'h00, 4'b0000);
    check_output();

    // Full contention rotates 0,1,2,3,0.
    apply_stimulus(4'b1111, 1'b1, 4'b1111);
    expect_out("rr0", 1'b1, 2'd0, 8'h10, 4'b0001); check_output();
    expect_out("rr1", 1'b1, 2'd1, 8'h11, 4'b0010); check_output();
    expect_out("rr2", 1'b1, 2'd2, 8'hA5, 4'b0100); check_output();
    expect_out("rr3", 1'b1, 2'd3, 8'h13, 4'b1000); check_output();
    expect_out("rr4", 1'b1, 2'd0, 8'h10, 4'b0001); check_output();

    // Stalled grant to channel 2 holds even after channel 0 arrives.
    do_reset();
    apply_stimulus(4'b0100, 1'b0, 4'b1111);
    expect_out("hold0", 1'b1, 2'd2, 8'hA5, 4'b0000); check_output();
    apply_stimulus(4'b0101, 1'b0, 4'b1111);
    expect_out("hold1", 1'b1, 2'd2, 8'hA5, 4'b0000); check_output();
    expect_out("hold2", 1'b1, 2'd2, 8'hA5, 4'b0000); check_output();
    apply_stimulus(4'b0101, 1'b1, 4'b1111);
    expect_out("hfire", 1'b1, 2'd2, 8'hA5, 4'b0100); check_output();
    expect_out("hnext", 1'b1, 2'd0, 8'h10, 4'b0001); check_output();

    // Burst on channel 1 against 0 and 3; LOCK=0 instance sees the same inputs.
    do_reset();
    apply_stimulus(4'b0001, 1'b1, 4'b1111);
    expect_out("pre",    1'b1, 2'd0, 8'h10, 4'b0001);
    expect_out("pre_nl", 1'b1, 2'd0, 8'h10, 4'b0001, 1'b1);
    check_output();
    apply_stimulus(4'b1011, 1'b1, 4'b1101);
    expect_out("burst1",    1'b1, 2'd1, 8'h11, 4'b0010);
    expect_out("burst1_nl", 1'b1, 2'd1, 8'h11, 4'b0010, 1'b1);
    check_output();
    expect_out("burst2",    1'b1, 2'd1, 8'h11, 4'b0010);
    expect_out("burst2_nl", 1'b1, 2'd3, 8'h13, 4'b1000, 1'b1);
    check_output();
    apply_stimulus(4'b1011, 1'b1, 4'b1111);
    expect_out("burst3",    1'b1, 2'd1, 8'h11, 4'b0010);
    expect_out("burst3_nl", 1'b1, 2'd0, 8'h10, 4'b0001, 1'b1);
    check_output();
    expect_out("after",    1'b1, 2'd3, 8'h13, 4'b1000);
    expect_out("after_nl", 1'b1, 2'd1, 8'h11, 4'b0010, 1'b1);
    check_output();

    // Reset while locked on channel 1 returns to pointer N-1.
    do_reset();
    apply_stimulus(4'b0001, 1'b1, 4'b1111);
    expect_out("lkpre", 1'b1, 2'd0, 8'h10, 4'b0001); check_output();
    apply_stimulus(4'b0010, 1'b1, 4'b0000);
    expect_out("lk1", 1'b1, 2'd1, 8'h11, 4'b0010); check_output();
    reset = 1'b1;
    apply_stimulus(4'b1111, 1'b0, 4'b1111);
    @(posedge clock);
    #1;
    reset = 1'b0;
    apply_stimulus(4'b1111, 1'b1, 4'b1111);
    expect_out("rstlk0", 1'b1, 2'd0, 8'h10, 4'b0001); check_output();
    expect_out("rstlk1", 1'b1, 2'd1, 8'h11, 4'b0010); check_output();

    // Idle inputs: default chosen index and no readies.
    apply_stimulus(4'b0000, 1'b1, 4'b1111);
    expect_out("idle0", 1'b0, 2'd3, 8'h00, 4'b0000); check_output();
    expect_out("idle1", 1'b0, 2'd3, 8'h00, 4'b0000); check_output();

    // Held requester drops: picking resumes in the same cycle.
    apply_stimulus(4'b0100, 1'b0, 4'b1111);
    expect_out("drop0", 1'b1, 2'd2, 8'hA5, 4'b0000); check_output();
    apply_stimulus(4'b1001, 1'b0, 4'b1111);
    expect_out("drop1", 1'b1, 2'd3, 8'h13, 4'b0000); check_output();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Parametrised N-channel round-robin arbiter with a ready/valid handshake. It is the successor to our single-input fixed-priority chooser. It adds three things: a registered round-robin pointer, grant hold while the output is stalled, and optional multi-beat burst locking. It sits between N producer ports and one shared consumer port in the interconnect, and it passes the winning payload through combinationally.

## Interface
- N, default 4: number of requesters, ≥2.
- W, default 8: payload width.
- LOCK, default 1: 1 keeps the grant for a burst until the `io_in_last` beat; 0 ignores `io_in_last`.
- CW, derived: $clog2(N), the width of the chosen index.

- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- io_in_valid  in  N  per-channel request.
- io_in_ready  out  N  per-channel accept.
- io_in_bits  in  N*W  payloads; channel i occupies bits [i*W +: W].
- io_in_last  in  N  marks the final beat of a burst.
- io_out_valid  out  1  a winner is present.
- io_out_ready  in  1  consumer accept.
- io_out_bits  out  W  winner payload.
- io_chosen  out  CW  winner index.

## Operation
- State registers:
  - last_grant[CW], reset value N-1.
  - state ∈ {IDLE, LOCKED}, reset value IDLE.
  - lock_idx[CW], reset value 0.
  - hold (1 bit), reset value 0.
  - held_idx[CW], reset value 0.
- Pick, IDLE with hold=0: scan (last_grant+1) mod N upward with wrap; the first channel with valid set wins.
- No valid input: io_out_valid=0 and io_chosen=N-1. This matches the legacy chooser's default.
- Hold: on a cycle with out_valid=1 and out_ready=0, set hold=1 and held_idx=chosen. While hold=1, chosen=held_idx regardless of other requests.
  - Hold clears on fire.
  - Hold also clears if io_in_valid[held_idx] drops; that is a protocol violation, and normal pick resumes the same cycle.
- LOCKED: only lock_idx is eligible; out_valid = io_in_valid[lock_idx] and chosen = lock_idx.
- Fire = io_out_valid & io_out_ready.
- io_in_ready[i] = io_out_ready & io_out_valid & (io_chosen==i); all other bits are 0.
- io_out_bits = io_in_bits[chosen] whenever out_valid=1, and 0 otherwise.
- On fire:
  - last_grant <= chosen.
  - If LOCK=1 and io_in_last[chosen]=0: state <= LOCKED and lock_idx <= chosen.
  - If the state is LOCKED and io_in_last=1: state <= IDLE.
- LOCK=0: state is constantly IDLE.
- Index arithmetic is modulo N for non-power-of-two N. CW-bit values ≥N never occur.

## Timing
- Data path: zero latency. Valid, bits and chosen are combinational from the inputs plus registered state.
- Every state update takes effect on the next rising clock edge.
- Throughput is one beat per cycle. Consecutive fires rotate priority across cycles.
- Simultaneous events:
  - Fire with last=1 while other channels are waiting: the next cycle picks from lock_idx+1.
  - Fire during hold: hold clears and the pointer advances in the same edge.
- Reset asserted mid-burst or mid-hold: the next cycle shows IDLE, hold=0, last_grant=N-1. No beat is lost, because reset-cycle handshakes are not counted.
- Outputs while reset is high: out_valid follows the inputs under the reset-state rules. The consumer must hold off on its own.

## Structure
- Package arb_pkg:
  - arb_state_e {IDLE, LOCKED}.
  - The function that computes CW.
  - The next-pointer helper, with modulo-N wrap.
- One sub-module, rr_pick: a combinational rotate-priority encoder.
  - Inputs: req[N], base[CW].
  - Outputs: any, idx[CW].
  - It is instantiated once; the top holds all registers and the LOCKED/hold masking.
- Target size is about 200 lines of RTL.

## Test plan
All scenarios use N=4, W=8, LOCK=1 unless stated.
- Reset, then all four valid with io_out_ready=1 held for four cycles → chosen sequence 0,1,2,3, then 0.
- Only channel 2 valid, bits 0xA5, ready=0 for 3 cycles; channel 0 raised at cycle 1 → chosen stays 2 with bits 0xA5; on ready=1, fire, then chosen=0.
- Channel 1 sends a 3-beat burst (last on beat 3), channels 0 and 3 also valid → three consecutive grants to 1, then grant 3.
- LOCK=0 with the same stimulus → grants alternate 1,3,0,1.
- Reset pulsed while LOCKED on channel 1, then all valid → next grant 0.
- No valid for 2 cycles → io_out_valid=0, io_chosen=3, io_in_ready=0000.
